// File: rtl/simd_issue_arb.sv
// simd_issue_arb: round-robin issue arbiter for one shared SIMD unit, with an
// in-flight tracker matching the unit latency and a credit-protected result FIFO.
module simd_issue_arb #(
    parameter int NREQ  = 2,
    parameter int LAT   = 2,
    parameter int DEPTH = 4,
    parameter int TAGW  = 9,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0][12:0]      req_op,
    input  logic [NREQ-1:0][67:0]      req_A,
    input  logic [NREQ-1:0][67:0]      req_B,
    input  logic [NREQ-1:0][TAGW-1:0]  req_tag,
    output logic [NREQ-1:0]            req_ready,
    output logic                       simd_en,
    output logic [12:0]                simd_operation,
    output logic [67:0]                simd_A,
    output logic [67:0]                simd_B,
    input  logic [67:0]                simd_res,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [67:0]                res_data,
    output logic [TAGW-1:0]            res_tag,
    output logic [PW-1:0]              res_port
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int UW = $clog2(DEPTH + LAT + 1);

    logic [PW-1:0]    rrPtr_q, rrPtr_d;
    logic [PW-1:0]    grantIdx;
    logic             grantAny;
    logic [NREQ-1:0]  grantVec;
    logic             canIssue;
    logic [UW-1:0]    usedCnt;

    logic             simdEn_q;
    logic [12:0]      simdOp_q;
    logic [67:0]      simdA_q, simdB_q;

    logic [LAT-1:0]   stValid_q;
    logic [TAGW-1:0]  stTag_q  [LAT];
    logic [PW-1:0]    stPort_q [LAT];

    logic [67:0]      memData_q [DEPTH];
    logic [TAGW-1:0]  memTag_q  [DEPTH];
    logic [PW-1:0]    memPort_q [DEPTH];
    logic [AW-1:0]    rdPtr_q, wrPtr_q;
    logic [CW-1:0]    fifoCount_q;

    logic             capture;
    logic             pop;

    function automatic logic [AW-1:0] ptrInc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Credit: every queued result and every in-flight op holds one FIFO slot.
    always_comb begin
        usedCnt = UW'(fifoCount_q);
        for (int i = 0; i < LAT; i++) begin
            usedCnt = usedCnt + UW'(stValid_q[i]);
        end
        canIssue = (usedCnt < UW'(DEPTH)) && !flush && !rst;
    end

    // Round-robin pick: first valid port at or after rrPtr_q, cyclically.
    always_comb begin
        int idx;
        grantVec = '0;
        grantIdx = '0;
        grantAny = 1'b0;
        idx      = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rrPtr_q) + i) % NREQ;
            if (!grantAny && canIssue && req_valid[idx]) begin
                grantAny      = 1'b1;
                grantIdx      = PW'(idx);
                grantVec[idx] = 1'b1;
            end
        end
        rrPtr_d = (int'(grantIdx) == NREQ - 1) ? '0 : PW'(int'(grantIdx) + 1);
    end

    assign req_ready = grantVec;

    // Issue registers toward the unit; rrPtr_q only advances on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rrPtr_q  <= '0;
            simdEn_q <= 1'b0;
            simdOp_q <= '0;
            simdA_q  <= '0;
            simdB_q  <= '0;
        end else begin
            simdEn_q <= grantAny;
            if (grantAny) begin
                rrPtr_q  <= rrPtr_d;
                simdOp_q <= req_op[grantIdx];
                simdA_q  <= req_A[grantIdx];
                simdB_q  <= req_B[grantIdx];
            end
        end
    end

    assign simd_en        = simdEn_q;
    assign simd_operation = simdOp_q;
    assign simd_A         = simdA_q;
    assign simd_B         = simdB_q;

    // In-flight valid bits shadow the unit pipeline; flush and reset drop them.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stValid_q <= '0;
        end else begin
            stValid_q[0] <= grantAny;
            for (int i = 1; i < LAT; i++) begin
                stValid_q[i] <= stValid_q[i-1];
            end
        end
    end

    // Tag/port payload travels alongside the valid bits; meaningless when invalid.
    always_ff @(posedge clk) begin
        stTag_q[0]  <= req_tag[grantIdx];
        stPort_q[0] <= grantIdx;
        for (int i = 1; i < LAT; i++) begin
            stTag_q[i]  <= stTag_q[i-1];
            stPort_q[i] <= stPort_q[i-1];
        end
    end

    assign capture = stValid_q[LAT-1] && !flush;
    assign pop     = res_valid && res_ready && !flush;

    // FIFO pointers and occupancy; simultaneous push and pop leave the count alone.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            fifoCount_q <= '0;
        end else begin
            if (capture) begin
                wrPtr_q <= ptrInc(wrPtr_q);
            end
            if (pop) begin
                rdPtr_q <= ptrInc(rdPtr_q);
            end
            if (capture && !pop) begin
                fifoCount_q <= fifoCount_q + CW'(1);
            end else if (!capture && pop) begin
                fifoCount_q <= fifoCount_q - CW'(1);
            end
        end
    end

    // Result storage; simd_res is only sampled when the tail op is valid.
    always_ff @(posedge clk) begin
        if (capture && !rst) begin
            memData_q[wrPtr_q] <= simd_res;
            memTag_q[wrPtr_q]  <= stTag_q[LAT-1];
            memPort_q[wrPtr_q] <= stPort_q[LAT-1];
        end
    end

    assign res_valid = (fifoCount_q != '0);
    assign res_data  = res_valid ? memData_q[rdPtr_q] : '0;
    assign res_tag   = res_valid ? memTag_q[rdPtr_q]  : '0;
    assign res_port  = res_valid ? memPort_q[rdPtr_q] : '0;

endmodule

// File: tb/tb_simd_issue_arb.sv
// Testbench for simd_issue_arb: randomized traffic in several profiles
// (sparse, saturated round-robin, backpressure, flush, reset) compared each
// cycle against a queue-based model of grants, issue registers and results.
module tb_simd_issue_arb;

    localparam int NREQ  = 2;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int TAGW  = 9;
    localparam int PW    = $clog2(NREQ);
    localparam int NCYC  = 1000;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       flush;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0][12:0]      req_op;
    logic [NREQ-1:0][67:0]      req_A;
    logic [NREQ-1:0][67:0]      req_B;
    logic [NREQ-1:0][TAGW-1:0]  req_tag;
    logic [NREQ-1:0]            req_ready;
    logic                       simd_en;
    logic [12:0]                simd_operation;
    logic [67:0]                simd_A;
    logic [67:0]                simd_B;
    wire  [67:0]                simd_res;
    logic                       res_valid;
    logic                       res_ready;
    logic [67:0]                res_data;
    logic [TAGW-1:0]            res_tag;
    logic [PW-1:0]              res_port;

    int checks   = 0;
    int failures = 0;

    simd_issue_arb #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_op(req_op), .req_A(req_A), .req_B(req_B),
        .req_tag(req_tag), .req_ready(req_ready),
        .simd_en(simd_en), .simd_operation(simd_operation),
        .simd_A(simd_A), .simd_B(simd_B), .simd_res(simd_res),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_port(res_port)
    );

    always #5 clk = ~clk;

    // The shared unit's behaviour: low two op bits pick add/and/xor/shift.
    function automatic logic [67:0] unitFunc(input logic [12:0] op,
                                             input logic [67:0] a,
                                             input logic [67:0] b);
        case (op[1:0])
            2'd0:    return a + b;
            2'd1:    return a & b;
            2'd2:    return a ^ b;
            default: return a << b[2:0];
        endcase
    endfunction

    // Emulated SIMD unit: the result sits on simd_res exactly during the cycle
    // that ends at issue edge + LAT, and the bus floats otherwise.
    logic        unitV [LAT-1];
    logic [67:0] unitR [LAT-1];

    always @(posedge clk) begin
        unitV[0] <= simd_en;
        unitR[0] <= unitFunc(simd_operation, simd_A, simd_B);
        for (int i = 1; i < LAT - 1; i++) begin
            unitV[i] <= unitV[i-1];
            unitR[i] <= unitR[i-1];
        end
    end

    assign simd_res = unitV[LAT-2] ? unitR[LAT-2] : 'z;

    // Reference model state: issued ops waiting on the unit, and queued results.
    typedef struct {
        logic [67:0]     data;
        logic [TAGW-1:0] tag;
        int              port;
        int              due;
    } entry_t;

    entry_t      infl[$];
    entry_t      fifoQ[$];
    int          mRr;
    int          mCyc;
    bit          mEn;
    logic [12:0] mOp;
    logic [67:0] mA;
    logic [67:0] mB;
    bit          mClean;

    // Counts every comparison and reports any mismatch in one line.
    task automatic checkOutput(input string name, input logic [127:0] obs,
                               input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    // Drives one cycle of inputs; the traffic profile changes every 100 cycles.
    task automatic applyStimulus(input int c);
        int seg;
        seg       = (c / 100) % 5;
        rst       = (c < 3) || (seg == 4 && $urandom_range(0, 19) == 0);
        flush     = (seg == 3 && $urandom_range(0, 7) == 0);
        res_ready = 1'b1;
        for (int p = 0; p < NREQ; p++) begin
            req_op[p]  = 13'($urandom);
            req_A[p]   = 68'({$urandom, $urandom, $urandom});
            req_B[p]   = 68'({$urandom, $urandom, $urandom});
            req_tag[p] = TAGW'($urandom);
        end
        case (seg)
            0: req_valid = {1'b0, ($urandom_range(0, 3) == 0)};
            1: req_valid = '1;
            2: begin
                req_valid = {1'b0, 1'b1};
                res_ready = ($urandom_range(0, 7) == 0);
            end
            default: begin
                req_valid = NREQ'($urandom);
                res_ready = ($urandom_range(0, 2) != 0);
            end
        endcase
    endtask

    // Main loop: drive at negedge, compare after settling, advance model at posedge.
    initial begin
        int              expG;
        int              used;
        logic [NREQ-1:0] expReady;
        bit              popOk;
        entry_t          e;

        rst = 1'b1; flush = 1'b0; req_valid = '0; res_ready = 1'b0;
        req_op = '0; req_A = '0; req_B = '0; req_tag = '0;
        mRr = 0; mCyc = 0; mEn = 1'b0; mOp = '0; mA = '0; mB = '0; mClean = 1'b1;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            applyStimulus(c);
            #1;

            expG     = -1;
            expReady = '0;
            used     = fifoQ.size() + infl.size();
            if (!rst && !flush && used < DEPTH) begin
                for (int i = 0; i < NREQ; i++) begin
                    int p;
                    p = (mRr + i) % NREQ;
                    if (expG < 0 && req_valid[p]) begin
                        expG        = p;
                        expReady[p] = 1'b1;
                    end
                end
            end

            if (c >= 1) begin
                checkOutput("req_ready", 128'(req_ready), 128'(expReady));
                checkOutput("simd_en", 128'(simd_en), 128'(mEn));
                checkOutput("simd_operation", 128'(simd_operation), 128'(mOp));
                checkOutput("simd_A", 128'(simd_A), 128'(mA));
                checkOutput("simd_B", 128'(simd_B), 128'(mB));
                checkOutput("res_valid", 128'(res_valid), 128'(fifoQ.size() != 0));
                if (fifoQ.size() != 0) begin
                    checkOutput("res_data", 128'(res_data), 128'(fifoQ[0].data));
                    checkOutput("res_tag", 128'(res_tag), 128'(fifoQ[0].tag));
                    checkOutput("res_port", 128'(res_port), 128'(fifoQ[0].port));
                end else if (mClean) begin
                    checkOutput("res_data_rst", 128'(res_data), 128'(0));
                    checkOutput("res_tag_rst", 128'(res_tag), 128'(0));
                    checkOutput("res_port_rst", 128'(res_port), 128'(0));
                end
            end

            @(posedge clk);
            if (rst) begin
                infl.delete();
                fifoQ.delete();
                mRr    = 0;
                mEn    = 1'b0;
                mOp    = '0;
                mA     = '0;
                mB     = '0;
                mClean = 1'b1;
            end else begin
                popOk = (fifoQ.size() != 0) && res_ready && !flush;
                if (popOk) begin
                    void'(fifoQ.pop_front());
                end
                while (infl.size() != 0 && infl[0].due == mCyc) begin
                    e = infl.pop_front();
                    if (!flush) begin
                        fifoQ.push_back(e);
                        mClean = 1'b0;
                    end
                end
                if (flush) begin
                    infl.delete();
                    fifoQ.delete();
                end
                if (expG >= 0) begin
                    e.data = unitFunc(req_op[expG], req_A[expG], req_B[expG]);
                    e.tag  = req_tag[expG];
                    e.port = expG;
                    e.due  = mCyc + LAT;
                    infl.push_back(e);
                    mEn = 1'b1;
                    mOp = req_op[expG];
                    mA  = req_A[expG];
                    mB  = req_B[expG];
                    mRr = (expG + 1) % NREQ;
                end else begin
                    mEn = 1'b0;
                end
            end
            mCyc++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
